// File: rtl/pattern_count_engine.sv
// Single-pass pattern statistics over a block of data memory, one byte per cycle.
// Optional result writeback after the scan is enabled by defining PATCNT_WRITEBACK_EN.
module pattern_count_engine #(
  parameter int unsigned PAT_W     = 5,
  parameter int unsigned N_BYTES   = 32,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned CNT_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [PAT_W-1:0]  pattern,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rd_data,
  output logic              mem_wr_en,
  output logic [7:0]        mem_wr_data,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  cnt_in_byte,
  output logic [CNT_W-1:0]  cnt_bytes_hit,
  output logic [CNT_W-1:0]  cnt_cross
);

  localparam int unsigned IDX_W = ADDR_W + 1;
  localparam int unsigned SUM_W = CNT_W + 4;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BYTES - 1);
  localparam logic [7:0]       PAT_MASK = 8'((1 << PAT_W) - 1);

`ifdef PATCNT_WRITEBACK_EN
  typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE, S_WB} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
`endif

  state_t r_state, w_state_nxt;

  logic [PAT_W-1:0]  r_pat, w_pat_nxt;
  logic [IDX_W-1:0]  r_k, w_k_nxt;
  logic [ADDR_W-1:0] r_mem_addr, w_addr_nxt;
  logic [7:0]        r_carry, w_carry_nxt;
  logic              r_have_prev, w_have_prev_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;
  logic [CNT_W-1:0]  r_cnt_in, w_cin_nxt;
  logic [CNT_W-1:0]  r_cnt_hit, w_chit_nxt;
  logic [CNT_W-1:0]  r_cnt_x, w_cx_nxt;
  logic [3:0]        w_inc_in, w_inc_x;
  logic [15:0]       w_x;
  logic              w_consume;
`ifdef PATCNT_WRITEBACK_EN
  logic              r_wr_en, w_wr_en_nxt;
  logic [7:0]        r_wr_data, w_wr_data_nxt;
  logic [1:0]        r_wb_cnt, w_wb_cnt_nxt;
`endif

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [3:0] b);
    logic [SUM_W-1:0] s;
    s = SUM_W'(a) + SUM_W'(b);
    return (s > SUM_W'(CNT_MAX)) ? CNT_MAX : CNT_W'(s);
  endfunction

  // Read data is valid for the address shown one cycle earlier.
  assign w_consume = ((r_state == S_RUN) && (r_k != '0)) || (r_state == S_DRAIN);
  assign w_x       = {r_carry, mem_rd_data};

  // Window matches: in-byte positions, then the PAT_W-1 windows straddling the previous byte.
  always_comb begin
    w_inc_in = '0;
    w_inc_x  = '0;
    for (int s = 0; s <= 8 - int'(PAT_W); s++) begin
      if (8'((mem_rd_data >> s) & PAT_MASK) == 8'(r_pat)) w_inc_in = w_inc_in + 4'd1;
    end
    for (int s = 9 - int'(PAT_W); s < 8; s++) begin
      if (16'((w_x >> s) & 16'(PAT_MASK)) == 16'(r_pat)) w_inc_x = w_inc_x + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (start) w_state_nxt = S_RUN;
      S_RUN:          if (r_k == LAST_IDX) w_state_nxt = S_DRAIN;
`ifdef PATCNT_WRITEBACK_EN
      S_DRAIN:        w_state_nxt = S_WB;
      S_WB:           if (r_wb_cnt == 2'd2) w_state_nxt = S_DONE;
`else
      S_DRAIN:        w_state_nxt = S_DONE;
`endif
      default:        w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_pat_nxt       = r_pat;
    w_k_nxt         = r_k;
    w_addr_nxt      = r_mem_addr;
    w_carry_nxt     = r_carry;
    w_have_prev_nxt = r_have_prev;
    w_cin_nxt       = r_cnt_in;
    w_chit_nxt      = r_cnt_hit;
    w_cx_nxt        = r_cnt_x;
    w_busy_nxt      = (w_state_nxt == S_RUN) || (w_state_nxt == S_DRAIN)
`ifdef PATCNT_WRITEBACK_EN
                      || (w_state_nxt == S_WB)
`endif
                      ;
    w_done_nxt      = (w_state_nxt == S_DONE);
`ifdef PATCNT_WRITEBACK_EN
    w_wr_en_nxt     = 1'b0;
    w_wr_data_nxt   = r_wr_data;
    w_wb_cnt_nxt    = r_wb_cnt;
`endif

    if (w_consume) begin
      w_cin_nxt = sat_add(r_cnt_in, w_inc_in);
      if (w_inc_in != '0) w_chit_nxt = sat_add(r_cnt_hit, 4'd1);
      w_cx_nxt        = sat_add(r_cnt_x, w_inc_in + (r_have_prev ? w_inc_x : 4'd0));
      w_carry_nxt     = mem_rd_data;
      w_have_prev_nxt = 1'b1;
    end

    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_pat_nxt       = pattern;
          w_k_nxt         = '0;
          w_addr_nxt      = ADDR_W'(BASE_ADDR);
          w_carry_nxt     = '0;
          w_have_prev_nxt = 1'b0;
          w_cin_nxt       = '0;
          w_chit_nxt      = '0;
          w_cx_nxt        = '0;
        end
      end
      S_RUN: begin
        if (r_k != LAST_IDX) begin
          w_k_nxt    = r_k + IDX_W'(1);
          w_addr_nxt = ADDR_W'(BASE_ADDR + 32'(r_k) + 1);
        end
      end
`ifdef PATCNT_WRITEBACK_EN
      // Results land after the reserved pattern byte at BASE_ADDR+N_BYTES.
      S_DRAIN: begin
        w_wr_en_nxt   = 1'b1;
        w_addr_nxt    = ADDR_W'(BASE_ADDR + N_BYTES + 1);
        w_wr_data_nxt = 8'(w_cin_nxt);
        w_wb_cnt_nxt  = 2'd0;
      end
      S_WB: begin
        if (r_wb_cnt == 2'd0) begin
          w_wr_en_nxt   = 1'b1;
          w_addr_nxt    = ADDR_W'(BASE_ADDR + N_BYTES + 2);
          w_wr_data_nxt = 8'(r_cnt_hit);
          w_wb_cnt_nxt  = 2'd1;
        end else if (r_wb_cnt == 2'd1) begin
          w_wr_en_nxt   = 1'b1;
          w_addr_nxt    = ADDR_W'(BASE_ADDR + N_BYTES + 3);
          w_wr_data_nxt = 8'(r_cnt_x);
          w_wb_cnt_nxt  = 2'd2;
        end
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pat       <= '0;
      r_k         <= '0;
      r_mem_addr  <= '0;
      r_carry     <= '0;
      r_have_prev <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_cnt_in    <= '0;
      r_cnt_hit   <= '0;
      r_cnt_x     <= '0;
`ifdef PATCNT_WRITEBACK_EN
      r_wr_en     <= 1'b0;
      r_wr_data   <= '0;
      r_wb_cnt    <= '0;
`endif
    end else begin
      r_pat       <= w_pat_nxt;
      r_k         <= w_k_nxt;
      r_mem_addr  <= w_addr_nxt;
      r_carry     <= w_carry_nxt;
      r_have_prev <= w_have_prev_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_cnt_in    <= w_cin_nxt;
      r_cnt_hit   <= w_chit_nxt;
      r_cnt_x     <= w_cx_nxt;
`ifdef PATCNT_WRITEBACK_EN
      r_wr_en     <= w_wr_en_nxt;
      r_wr_data   <= w_wr_data_nxt;
      r_wb_cnt    <= w_wb_cnt_nxt;
`endif
    end
  end

  assign mem_addr      = r_mem_addr;
  assign busy          = r_busy;
  assign done          = r_done;
  assign cnt_in_byte   = r_cnt_in;
  assign cnt_bytes_hit = r_cnt_hit;
  assign cnt_cross     = r_cnt_x;
`ifdef PATCNT_WRITEBACK_EN
  assign mem_wr_en     = r_wr_en;
  assign mem_wr_data   = r_wr_data;
`else
  assign mem_wr_en     = 1'b0;
  assign mem_wr_data   = 8'd0;
`endif

endmodule

// File: tb/tb_pattern_count_engine.sv
// Randomized bench for pattern_count_engine: default-width and 7-bit-count instances
// share one memory image and are checked against a bit-string reference model.
module tb_pattern_count_engine;

  localparam int unsigned PAT_W   = 5;
  localparam int unsigned N_BYTES = 32;
  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned BASE    = 0;
  localparam int unsigned CW8     = 8;
  localparam int unsigned CW7     = 7;
`ifdef PATCNT_WRITEBACK_EN
  localparam int EXP_LAT = N_BYTES + 4;
`else
  localparam int EXP_LAT = N_BYTES + 1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset, start;
  logic [PAT_W-1:0]  pattern;
  logic [ADDR_W-1:0] addr8, addr7;
  logic [7:0]        rd8, rd7, wd8, wd7;
  logic              wr8, wr7, busy8, busy7, done8, done7;
  logic [CW8-1:0]    cin8, chit8, cx8;
  logic [CW7-1:0]    cin7, chit7, cx7;

  logic [7:0] mem [256];
  int n_total = 0;
  int n_bad   = 0;
  int wr_seen = 0;
  int cyc     = 0;
  int wr_cyc[$];

  pattern_count_engine #(.PAT_W(PAT_W), .N_BYTES(N_BYTES), .ADDR_W(ADDR_W),
                         .BASE_ADDR(BASE), .CNT_W(CW8)) u_dut (
    .clk(clk), .reset(reset), .start(start), .pattern(pattern),
    .mem_addr(addr8), .mem_rd_data(rd8), .mem_wr_en(wr8), .mem_wr_data(wd8),
    .busy(busy8), .done(done8),
    .cnt_in_byte(cin8), .cnt_bytes_hit(chit8), .cnt_cross(cx8));

  pattern_count_engine #(.PAT_W(PAT_W), .N_BYTES(N_BYTES), .ADDR_W(ADDR_W),
                         .BASE_ADDR(BASE), .CNT_W(CW7)) u_dut7 (
    .clk(clk), .reset(reset), .start(start), .pattern(pattern),
    .mem_addr(addr7), .mem_rd_data(rd7), .mem_wr_en(wr7), .mem_wr_data(wd7),
    .busy(busy7), .done(done7),
    .cnt_in_byte(cin7), .cnt_bytes_hit(chit7), .cnt_cross(cx7));

  // Synchronous-read memory; only the default instance may write.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    rd8 <= mem[addr8];
    rd7 <= mem[addr7];
    if (wr8 === 1'b1) begin
      mem[addr8] = wd8;
      wr_seen <= wr_seen + 1;
      wr_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input longint got, input longint exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference: scan the MSB-first bit string for every window position.
  function automatic void model(input logic [PAT_W-1:0] pat, input int cw,
                                output longint e_in, output longint e_hit, output longint e_x);
    bit     bits[$];
    int     hits[N_BYTES];
    bit     m;
    longint mx;
    for (int b = 0; b < int'(N_BYTES); b++) begin
      hits[b] = 0;
      for (int j = 7; j >= 0; j--) bits.push_back(mem[BASE + b][j]);
    end
    e_in = 0; e_hit = 0; e_x = 0;
    for (int i = 0; i + int'(PAT_W) <= 8 * int'(N_BYTES); i++) begin
      m = 1'b1;
      for (int t = 0; t < int'(PAT_W); t++)
        if (bits[i + t] != pat[int'(PAT_W) - 1 - t]) m = 1'b0;
      if (m) begin
        e_x++;
        if ((i % 8) + int'(PAT_W) <= 8) begin
          e_in++;
          hits[i / 8]++;
        end
      end
    end
    for (int b = 0; b < int'(N_BYTES); b++) if (hits[b] > 0) e_hit++;
    mx = (longint'(1) << cw) - 1;
    if (e_in > mx)  e_in  = mx;
    if (e_hit > mx) e_hit = mx;
    if (e_x > mx)   e_x   = mx;
  endfunction

  task automatic run_scan(input logic [PAT_W-1:0] pat, input bit poke);
    longint e_in, e_hit, e_x, f_in, f_hit, f_x;
    int lat, wr_before, nq;
    model(pat, CW8, e_in, e_hit, e_x);
    model(pat, CW7, f_in, f_hit, f_x);
    wr_before = wr_seen;
    @(negedge clk);
    start = 1'b1; pattern = pat;
    @(posedge clk); #1;
    start = 1'b0; pattern = ~pat;
    check("busy_after_start", longint'(busy8), 1);
    check("done_after_start", longint'(done8), 0);
    check("cross_cleared", longint'(cx8), 0);
    lat = 0;
    while (done8 !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (poke && lat == 4) begin start = 1'b1; pattern = 5'($urandom); end
      if (poke && lat == 5) start = 1'b0;
    end
    check("done_latency", longint'(lat), longint'(EXP_LAT));
    check("busy_at_done", longint'(busy8), 0);
    check("cnt_in_byte", longint'(cin8), e_in);
    check("cnt_bytes_hit", longint'(chit8), e_hit);
    check("cnt_cross", longint'(cx8), e_x);
    check("done7", longint'(done7), 1);
    check("cnt_in_byte7", longint'(cin7), f_in);
    check("cnt_bytes_hit7", longint'(chit7), f_hit);
    check("cnt_cross7", longint'(cx7), f_x);
`ifdef PATCNT_WRITEBACK_EN
    check("wb_writes", longint'(wr_seen - wr_before), 3);
    check("wb_in_byte", longint'(mem[BASE + N_BYTES + 1]), e_in & 8'hFF);
    check("wb_bytes_hit", longint'(mem[BASE + N_BYTES + 2]), e_hit & 8'hFF);
    check("wb_cross", longint'(mem[BASE + N_BYTES + 3]), e_x & 8'hFF);
    nq = wr_cyc.size();
    if (nq >= 3) check("wb_consecutive", longint'(wr_cyc[nq-1] - wr_cyc[nq-3]), 2);
    else check("wb_log_size", longint'(nq), 3);
`else
    nq = wr_before;
    check("no_writes", longint'(wr_seen), longint'(nq));
`endif
    repeat (2) @(posedge clk);
    #1 check("counts_hold", longint'(cx8), e_x);
  endtask

  task automatic fill(input logic [7:0] v);
    for (int i = 0; i < 256; i++) mem[i] = v;
  endtask

  task automatic fill_random(input int mode);
    for (int i = 0; i < int'(N_BYTES); i++) begin
      case (mode)
        0:       mem[BASE + i] = 8'($urandom);
        1:       mem[BASE + i] = ($urandom_range(0, 2) == 0) ? 8'($urandom) :
                                 (($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF);
        default: mem[BASE + i] = 8'($urandom) & 8'($urandom);
      endcase
    end
  endtask

  initial begin
    int wr_b;
    reset = 1'b1; start = 1'b0; pattern = '0;
    fill(8'h00);
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", longint'(busy8), 0);
    check("rst_done", longint'(done8), 0);
    check("rst_addr", longint'(addr8), 0);
    check("rst_cnt_in", longint'(cin8), 0);
    check("rst_cnt_x", longint'(cx8), 0);
    check("rst_wr_en", longint'(wr8), 0);
    @(negedge clk) reset = 1'b0;

    fill(8'h00);
    run_scan(5'b00000, 1'b0);
    fill(8'h55);
    run_scan(5'b10101, 1'b0);
    fill(8'h00); mem[3] = 8'h03; mem[4] = 8'hE0;
    run_scan(5'b11111, 1'b0);
    fill(8'h00); mem[5] = 8'h1F;
    run_scan(5'b11111, 1'b0);
    run_scan(5'b00000, 1'b1);
    fill(8'hFF);
    run_scan(5'b11111, 1'b0);

    // Abort a run with reset partway through.
    fill(8'h00);
    @(negedge clk); start = 1'b1; pattern = '0;
    @(posedge clk); #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    check("abort_busy", longint'(busy8), 0);
    check("abort_done", longint'(done8), 0);
    check("abort_addr", longint'(addr8), 0);
    check("abort_cnt_x", longint'(cx8), 0);
    wr_b = wr_seen;
    repeat (3) @(posedge clk);
    #1 check("abort_no_writes", longint'(wr_seen), longint'(wr_b));
    @(negedge clk) reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("abort_stays_idle", longint'(busy8), 0);

    for (int r = 0; r < 12; r++) begin
      fill_random(r % 3);
      run_scan((r % 4 == 0) ? 5'(mem[BASE + 2] >> 3) : 5'($urandom), r[0]);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
